// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the physical memory bus controller.
// Flash support is selected by MEM_BUS_FLASH_EN at build time.
package mem_bus_ctrl_pkg;

    // state        | meaning
    // IDLE/DONE    | bus quiet; DONE pulses done_o for one cycle
    // SRAM_RD      | ce/oe low for SRAM_WAIT cycles
    // SRAM_WR_*    | setup 1 cycle, we pulse SRAM_WAIT cycles, hold 1 cycle
    // FLASH_LO/HI  | low then high halfword, FLASH_WAIT cycles each
    // ROM_RD       | sync ROM data returns; SIMPLE = serial, ignored or error
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SRAM_RD,
        ST_SRAM_WR_SETUP,
        ST_SRAM_WR_PULSE,
        ST_SRAM_WR_HOLD,
        ST_FLASH_LO,
        ST_FLASH_HI,
        ST_ROM_RD,
        ST_SIMPLE,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        DEV_NONE,
        DEV_SRAM,
        DEV_ROM,
        DEV_FLASH,
        DEV_SERIAL
    } dev_e;

    localparam logic [15:0] SER_DATA_OFS     = 16'h03F8;
    localparam logic [15:0] SER_STAT_OFS     = 16'h03FC;
    localparam logic [15:0] SER_STAT_ALT_OFS = 16'hF010;
    localparam int          STAT_TX_RDY_BIT  = 0;
    localparam int          STAT_RX_VLD_BIT  = 1;

    function automatic dev_e pick_dev(input logic hit, input logic sram, input logic rom,
                                      input logic flash, input logic serial);
        dev_e dev;
        if (!hit)        dev = DEV_NONE;
        else if (sram)   dev = DEV_SRAM;
        else if (rom)    dev = DEV_ROM;
        else if (flash)  dev = DEV_FLASH;
        else if (serial) dev = DEV_SERIAL;
        else             dev = DEV_NONE;
        return dev;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_flash_rd_seq.sv
// Two-halfword flash read sequencer: per-phase wait counter and {hi,lo} assembly.
// Only built when MEM_BUS_FLASH_EN is defined.
`ifdef MEM_BUS_FLASH_EN
module flash_rd_seq #(
    parameter int unsigned FLASH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        lo_i,
    input  logic        hi_i,
    input  logic [21:0] base_i,
    input  logic [15:0] flash_dq_i,
    output logic        phase_done_o,
    output logic [31:0] word_o,
    output logic [22:0] flash_addr_o,
    output logic        flash_ce_n,
    output logic        flash_oe_n
);

    localparam logic [3:0] CNT_INIT = 4'(FLASH_WAIT - 1);

    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lo_q, lo_d;
    logic        active;

    assign active = lo_i | hi_i;

    always_comb begin
        cnt_d = cnt_q;
        lo_d  = lo_q;
        if (load_i)
            cnt_d = CNT_INIT;
        else if (active && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
        if (lo_i && cnt_q == 4'd0)
            lo_d = flash_dq_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
            lo_q  <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
            lo_q  <= lo_d;
        end
    end

    assign phase_done_o = active && (cnt_q == 4'd0);
    // High halfword goes straight from the pins into the word on the last HI cycle.
    assign word_o       = {flash_dq_i, lo_q};
    assign flash_addr_o = active ? {base_i, hi_i} : 23'h0;
    assign flash_ce_n   = ~active;
    assign flash_oe_n   = ~active;

endmodule
`endif

// File: rtl/mem_bus_ctrl.sv
// Physical memory bus controller: SRAM, flash, boot ROM and UART accesses for pipeline load/store.
// Define MEM_BUS_FLASH_EN to build the flash read path; otherwise flash selects complete with an error.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_WAIT  = 1,
    parameter int unsigned FLASH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] addr_i,
    input  logic        hit_i,
    input  logic        sram_ce_i,
    input  logic        flash_ce_i,
    input  logic        rom_ce_i,
    input  logic        serial_ce_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        addr_err_o,
    output logic [19:0] sram_addr_o,
    input  logic [31:0] sram_dq_i,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n,
    output logic [22:0] flash_addr_o,
    input  logic [15:0] flash_dq_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic [9:0]  rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        uart_rx_ack_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_start_o,
    input  logic        uart_tx_busy_i
);

    localparam logic [3:0] SRAM_CNT_INIT = 4'(SRAM_WAIT - 1);

    state_e      state_q, state_d;
    dev_e        dev_q, dev_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rx_ack, tx_start;
    logic        fl_phase_done;
    logic [31:0] fl_word;
    logic        fl_load;
    logic        wr_phase;
    logic        unused_addr;

    always_comb begin
        state_d  = state_q;
        dev_d    = dev_q;
        err_d    = err_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        rx_ack   = 1'b0;
        tx_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    sel_d   = sel_i;
                    wdata_d = wdata_i;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    dev_d   = pick_dev(hit_i, sram_ce_i, rom_ce_i, flash_ce_i, serial_ce_i);
                    case (dev_d)
                        DEV_SRAM:   state_d = we_i ? ST_SRAM_WR_SETUP : ST_SRAM_RD;
                        DEV_ROM:    state_d = we_i ? ST_SIMPLE : ST_ROM_RD;
`ifdef MEM_BUS_FLASH_EN
                        DEV_FLASH:  state_d = we_i ? ST_SIMPLE : ST_FLASH_LO;
`else
                        DEV_FLASH: begin
                            state_d = ST_SIMPLE;
                            err_d   = 1'b1;
                        end
`endif
                        DEV_SERIAL: state_d = ST_SIMPLE;
                        default: begin
                            state_d = ST_SIMPLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_SRAM_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = sram_dq_i;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SRAM_WR_SETUP: state_d = ST_SRAM_WR_PULSE;
            ST_SRAM_WR_PULSE: begin
                if (cnt_q == 4'd0)
                    state_d = ST_SRAM_WR_HOLD;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_SRAM_WR_HOLD: state_d = ST_DONE;
            ST_FLASH_LO: begin
                if (fl_phase_done)
                    state_d = ST_FLASH_HI;
            end
            ST_FLASH_HI: begin
                if (fl_phase_done) begin
                    rdata_d = fl_word;
                    state_d = ST_DONE;
                end
            end
            ST_ROM_RD: begin
                rdata_d = rom_data_i;
                state_d = ST_DONE;
            end
            ST_SIMPLE: begin
                state_d = ST_DONE;
                if (dev_q == DEV_SERIAL && !err_q) begin
                    if (!we_q) begin
                        if (addr_q[15:0] == SER_DATA_OFS) begin
                            if (uart_rx_valid_i) begin
                                rdata_d = {24'h0, uart_rx_data_i};
                                rx_ack  = 1'b1;
                            end
                        end else if (addr_q[15:0] == SER_STAT_OFS ||
                                     addr_q[15:0] == SER_STAT_ALT_OFS) begin
                            rdata_d                  = 32'h0;
                            rdata_d[STAT_TX_RDY_BIT] = ~uart_tx_busy_i;
                            rdata_d[STAT_RX_VLD_BIT] = uart_rx_valid_i;
                        end
                    end else if (addr_q[15:0] == SER_DATA_OFS && !uart_tx_busy_i) begin
                        tx_start = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q && (state_d == ST_SRAM_RD || state_d == ST_SRAM_WR_PULSE))
            cnt_d = SRAM_CNT_INIT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dev_q   <= DEV_NONE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdata_q <= 32'h0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            err_q   <= err_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fl_load = (state_d != state_q) &&
                     (state_d == ST_FLASH_LO || state_d == ST_FLASH_HI);

`ifdef MEM_BUS_FLASH_EN
    flash_rd_seq #(
        .FLASH_WAIT (FLASH_WAIT)
    ) u_flash_rd_seq (
        .clk          (clk),
        .rst          (rst),
        .load_i       (fl_load),
        .lo_i         (state_q == ST_FLASH_LO),
        .hi_i         (state_q == ST_FLASH_HI),
        .base_i       (addr_q[23:2]),
        .flash_dq_i   (flash_dq_i),
        .phase_done_o (fl_phase_done),
        .word_o       (fl_word),
        .flash_addr_o (flash_addr_o),
        .flash_ce_n   (flash_ce_n),
        .flash_oe_n   (flash_oe_n)
    );
`else
    logic unused_flash;

    assign fl_phase_done = 1'b0;
    assign fl_word       = 32'h0;
    assign flash_addr_o  = 23'h0;
    assign flash_ce_n    = 1'b1;
    assign flash_oe_n    = 1'b1;
    assign unused_flash  = ^{flash_dq_i, addr_q[23:22], fl_load, 4'(FLASH_WAIT)};
`endif

    assign unused_addr = ^addr_q[31:24];

    assign wr_phase   = (state_q == ST_SRAM_WR_SETUP) || (state_q == ST_SRAM_WR_PULSE) ||
                        (state_q == ST_SRAM_WR_HOLD);
    assign done_o     = (state_q == ST_DONE);
    assign addr_err_o = done_o & err_q;
    assign stall_o    = req_i & ~done_o;
    assign rdata_o    = rdata_q;

    assign sram_addr_o = addr_q[21:2];
    assign sram_dq_o   = wdata_q;
    assign sram_dq_oe  = wr_phase;
    assign sram_ce_n   = ~(wr_phase || state_q == ST_SRAM_RD);
    assign sram_oe_n   = ~(state_q == ST_SRAM_RD);
    assign sram_we_n   = ~(state_q == ST_SRAM_WR_PULSE);
    assign sram_be_n   = (state_q == ST_SRAM_RD) ? 4'b0000 : (wr_phase ? ~sel_q : 4'b1111);

    // The ROM registers its address, so present it on the accepting edge to get data in ROM_RD.
    assign rom_addr_o = (state_q == ST_IDLE && req_i) ? addr_i[11:2] : addr_q[11:2];

    assign uart_rx_ack_o   = rx_ack;
    assign uart_tx_start_o = tx_start;
    assign uart_tx_data_o  = wdata_q[7:0];

endmodule
